muc_iter_nbit: RTL

- Parametrised, sequential sign-magnitude multiplier; next generation of the 4-bit 2x2-kernel multiplier.
- Magnitudes are WIDTH bits. Each cycle multiplies one 2-bit digit of b against all 2-bit digits of a, using WIDTH/2 2x2 kernels, and accumulates the result.
- Each kernel is exact or approximate, selected per transaction.
- Sits in the DNN MAC datapath behind a valid/ready handshake and feeds the accumulator stage.

---
 rtl/muc_pkg.sv | 13 +
 rtl/muc_iter_nbit_if.sv | 26 ++
 rtl/mul2x2_kernel.sv | 20 ++
 rtl/muc_iter_nbit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/muc_pkg.sv
// Shared types and constants for the iterative sign-magnitude multiplier.
package muc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned KERN_W    = 2;
    localparam logic [3:0]  APPROX_33 = 4'd7;

endpackage

// File: rtl/muc_iter_nbit_if.sv
// Operand/result handshake bundle for muc_iter_nbit; slave is the multiplier side.
interface muc_iter_nbit_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   asign;
    logic                   bsign;
    logic                   approx;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     m;
    logic                   sign;

    modport master (
        output in_valid, a, b, asign, bsign, approx, out_ready,
        input  in_ready, out_valid, m, sign
    );

    modport slave (
        input  in_valid, a, b, asign, bsign, approx, out_ready,
        output in_ready, out_valid, m, sign
    );
endinterface

// File: rtl/mul2x2_kernel.sv
// 2x2-bit unsigned multiplier kernel; approximate mode maps 3*3 to 7.
module mul2x2_kernel
    import muc_pkg::*;
(
    input  logic [KERN_W-1:0]   x,
    input  logic [KERN_W-1:0]   y,
    input  logic                approx,
    output logic [2*KERN_W-1:0] p,
    output logic                hit
);

    always_comb begin
        hit = (x == 2'd3) && (y == 2'd3);
        p   = (2*KERN_W)'(x) * (2*KERN_W)'(y);
        if (approx && hit) begin
            p = APPROX_33;
        end
    end

endmodule

// File: rtl/muc_iter_nbit.sv
// Iterative sign-magnitude multiplier: one 2-bit digit of b per cycle against all digits of a.
// Optional saturating approximation-hit counter enabled by MUC_ERR_CNT_EN.
module muc_iter_nbit
    import muc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    muc_iter_nbit_if.slave     bus
`ifdef MUC_ERR_CNT_EN
    ,
    output logic [15:0]        err_cnt
`endif
);

    localparam int unsigned NDIG = WIDTH / 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned HCW  = $clog2(NDIG + 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("muc_iter_nbit: WIDTH must be even and >= 2");
        end
    endgenerate

    state_e state;
    state_e state_nxt;

    logic [WIDTH-1:0]  a_l;
    logic [WIDTH-1:0]  b_l;
    logic              sign_l;
    logic              approx_l;
    logic [PW-1:0]     acc;
    logic [KW-1:0]     k;

    logic              accept;
    logic              last;
    logic [KERN_W-1:0] b_dig;
    logic [3:0]        kp  [NDIG];
    logic [NDIG-1:0]   hit;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;

    assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last         = (k == KW'(NDIG - 1));
    assign b_dig        = b_l[{k, 1'b0} +: KERN_W];

    // One kernel per digit of a, all fed the current digit of b.
    generate
        for (genvar j = 0; j < NDIG; j++) begin : g_kern
            mul2x2_kernel u_kern (
                .x      (a_l[KERN_W*j +: KERN_W]),
                .y      (b_dig),
                .approx (approx_l),
                .p      (kp[j]),
                .hit    (hit[j])
            );
        end
    endgenerate

    always_comb begin
        pp = '0;
        for (int j = 0; j < NDIG; j++) begin
            pp = pp + (PW'(kp[j]) << (KERN_W * j));
        end
        acc_sum = acc + (pp << {k, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (last)   state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = accept ? BUSY : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, accumulator, digit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_l           <= '0;
            b_l           <= '0;
            sign_l        <= 1'b0;
            approx_l      <= 1'b0;
            acc           <= '0;
            k             <= '0;
            bus.m         <= '0;
            bus.sign      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            a_l           <= bus.a;
            b_l           <= bus.b;
            sign_l        <= bus.asign ^ bus.bsign;
            approx_l      <= bus.approx;
            acc           <= '0;
            k             <= '0;
            bus.out_valid <= 1'b0;
        end else if (state == BUSY) begin
            acc <= acc_sum;
            k   <= k + KW'(1);
            if (last) begin
                bus.m         <= acc_sum;
                bus.sign      <= sign_l;
                bus.out_valid <= 1'b1;
            end
        end else if ((state == DONE) && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef MUC_ERR_CNT_EN
    logic [HCW-1:0] hit_cnt;
    logic [16:0]    err_sum;

    always_comb begin
        hit_cnt = '0;
        for (int j = 0; j < NDIG; j++) begin
            hit_cnt = hit_cnt + HCW'(hit[j]);
        end
        err_sum = {1'b0, err_cnt} + 17'(hit_cnt);
    end

    // Saturating count of approximated 3x3 kernel evaluations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((state == BUSY) && approx_l) begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`else
    logic unused_hit;
    assign unused_hit = ^hit;
`endif

endmodule
